// File: rtl/bayer_pkg.sv
// Bayer mosaic phase encodings and phase-to-channel mapping, shared with the demosaic stage.
package bayer_pkg;
  localparam int DW_DEF = 10;

  typedef enum logic [1:0] {
    PH_GR = 2'b00,
    PH_R  = 2'b01,
    PH_B  = 2'b10,
    PH_GB = 2'b11
  } bayer_ph_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } bayer_ch_e;

  function automatic bayer_ch_e ph2ch(input bayer_ph_e ph);
    case (ph)
      PH_R:    return CH_R;
      PH_B:    return CH_B;
      default: return CH_G;
    endcase
  endfunction
endpackage

// File: rtl/raw_line_buffer.sv
// One-line RAW delay: read-before-write RAM with a registered read port.
module raw_line_buffer #(
  parameter  int LINE_WIDTH = 640,
  parameter  int DW         = 10,
  localparam int AW         = $clog2(LINE_WIDTH)
) (
  input  logic          CLK,
  input  logic          en,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [LINE_WIDTH];

  // Contents are never cleared; the top masks them until a full line is written.
  always_ff @(posedge CLK) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end
endmodule

// File: rtl/rgb_bayer_remosaic.sv
// Re-mosaics RGB pixels into a Bayer RAW stream with current/previous-line taps and parity.
module rgb_bayer_remosaic
  import bayer_pkg::*;
#(
  parameter int LINE_WIDTH = 640,
  parameter int DW         = DW_DEF,
  parameter int ROW_W      = 12
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          SOF_IN,
  input  logic          DATA_EN_IN,
  input  logic [DW-1:0] R_IN,
  input  logic [DW-1:0] G_IN,
  input  logic [DW-1:0] B_IN,
  output logic          DATA_EN,
  output logic [DW-1:0] D0,
  output logic [DW-1:0] D1,
  output logic          X,
  output logic          Y
);
  localparam int CW     = $clog2(LINE_WIDTH);
  localparam int STAGES = 0;

  typedef struct packed {
    logic [DW-1:0] raw;
    logic          x;
    logic          y;
    logic          row0;
  } tap_t;

  logic [CW-1:0]    col, cur_col;
  logic [ROW_W-1:0] row, cur_row;
  logic [STAGES:0]  vld_pipe;
  tap_t             tap_d, tap_q;
  logic [DW-1:0]    prev_raw;

  // SOF restarts the frame on the very pixel that carries it.
  always_comb begin
    cur_col    = SOF_IN ? '0 : col;
    cur_row    = SOF_IN ? '0 : row;
    tap_d.x    = cur_col[0];
    tap_d.y    = cur_row[0];
    tap_d.row0 = (cur_row == '0);
    case (ph2ch(bayer_ph_e'({cur_row[0], cur_col[0]})))
      CH_R:    tap_d.raw = R_IN;
      CH_B:    tap_d.raw = B_IN;
      default: tap_d.raw = G_IN;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col      <= '0;
      row      <= '0;
      vld_pipe <= '0;
      tap_q    <= '{raw: '0, x: 1'b0, y: 1'b0, row0: 1'b1};
    end else begin
      vld_pipe[0] <= DATA_EN_IN;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (DATA_EN_IN) begin
        tap_q <= tap_d;
        if (cur_col == CW'(LINE_WIDTH - 1)) begin
          col <= '0;
          row <= cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

  raw_line_buffer #(.LINE_WIDTH(LINE_WIDTH), .DW(DW)) u_lbuf (
    .CLK   (CLK),
    .en    (DATA_EN_IN),
    .addr  (cur_col),
    .wdata (tap_d.raw),
    .rdata (prev_raw)
  );

  assign DATA_EN = vld_pipe[STAGES];
  assign D0      = tap_q.raw;
  assign D1      = tap_q.row0 ? '0 : prev_raw;
  assign X       = tap_q.x;
  assign Y       = tap_q.y;
endmodule

// File: tb/tb_rgb_bayer_remosaic.sv
// Scoreboard bench for rgb_bayer_remosaic with LINE_WIDTH=4 and hand-computed vectors.
module tb_rgb_bayer_remosaic;
  localparam int DW = 10;

  logic          CLK, RST_N, SOF_IN, DATA_EN_IN, DATA_EN, X, Y;
  logic [DW-1:0] R_IN, G_IN, B_IN, D0, D1;

  typedef struct packed {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          x;
    logic          y;
  } exp_t;

  exp_t q[$];
  exp_t e, last;
  bit   have_last;
  int   checks = 0;
  int   errors = 0;

  rgb_bayer_remosaic #(.LINE_WIDTH(4), .DW(DW), .ROW_W(12)) dut (
    .CLK(CLK), .RST_N(RST_N), .SOF_IN(SOF_IN), .DATA_EN_IN(DATA_EN_IN),
    .R_IN(R_IN), .G_IN(G_IN), .B_IN(B_IN),
    .DATA_EN(DATA_EN), .D0(D0), .D1(D1), .X(X), .Y(Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: pops on every valid output, checks hold on every gap cycle.
  always @(negedge CLK) begin
    if (!RST_N) begin
      have_last = 1'b0;
    end else if (DATA_EN) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out got d0=%0d d1=%0d x=%0d y=%0d, none expected", D0, D1, X, Y);
      end else begin
        e = q.pop_front();
        if (D0 !== e.d0 || D1 !== e.d1 || X !== e.x || Y !== e.y) begin
          errors++;
          $display("FAIL pixel got d0=%0d d1=%0d x=%0d y=%0d exp d0=%0d d1=%0d x=%0d y=%0d",
                   D0, D1, X, Y, e.d0, e.d1, e.x, e.y);
        end
        last      = e;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      checks++;
      if (D0 !== last.d0 || D1 !== last.d1 || X !== last.x || Y !== last.y) begin
        errors++;
        $display("FAIL hold got d0=%0d d1=%0d x=%0d y=%0d exp d0=%0d d1=%0d x=%0d y=%0d",
                 D0, D1, X, Y, last.d0, last.d1, last.x, last.y);
      end
    end
  end

  task automatic px(input logic sof, input int r, input int g, input int b,
                    input int d0, input int d1, input logic x, input logic y);
    exp_t t;
    @(posedge CLK); #1;
    SOF_IN = sof; DATA_EN_IN = 1'b1;
    R_IN = DW'(r); G_IN = DW'(g); B_IN = DW'(b);
    t.d0 = DW'(d0); t.d1 = DW'(d1); t.x = x; t.y = y;
    q.push_back(t);
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    SOF_IN = 1'b0; DATA_EN_IN = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if (DATA_EN !== 1'b0 || D0 !== '0 || D1 !== '0 || X !== 1'b0 || Y !== 1'b0) begin
      errors++;
      $display("FAIL %s got en=%0d d0=%0d d1=%0d x=%0d y=%0d exp all 0", tag, DATA_EN, D0, D1, X, Y);
    end
  endtask

  initial begin
    RST_N = 1'b1; SOF_IN = 1'b0; DATA_EN_IN = 1'b0;
    R_IN = '0; G_IN = '0; B_IN = '0;
    #1 RST_N = 1'b0;
    #3 check_reset("reset_init");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;

    // Two full lines, constant colours, no SOF: release alone starts at (0,0).
    px(0, 100, 200, 300, 200, 0,   0, 0);
    px(0, 100, 200, 300, 100, 0,   1, 0);
    px(0, 100, 200, 300, 200, 0,   0, 0);
    px(0, 100, 200, 300, 100, 0,   1, 0);
    px(0, 100, 200, 300, 300, 200, 0, 1);
    px(0, 100, 200, 300, 200, 100, 1, 1);
    px(0, 100, 200, 300, 300, 200, 0, 1);
    px(0, 100, 200, 300, 200, 100, 1, 1);
    // Row 2 starts, then reset mid-frame.
    px(0, 100, 200, 300, 200, 300, 0, 0);
    px(0, 100, 200, 300, 100, 200, 1, 0);
    idle(); idle();
    #3 RST_N = 1'b0;
    #1 check_reset("reset_mid");
    @(negedge CLK); check_reset("reset_hold");
    @(posedge CLK); #1 RST_N = 1'b1;

    // First pixel after release, then bubbles 1,0,0,1.
    px(0, 11, 22, 33, 22, 0, 0, 0);
    px(0, 11, 22, 33, 11, 0, 1, 0);
    idle(); idle();
    px(0, 11, 22, 33, 22, 0, 0, 0);
    px(0, 11, 22, 33, 11, 0, 1, 0);

    // New frame, SOF re-asserted on column 2 of row 1.
    px(1, 901, 1,   801, 1,  0,  0, 0);
    px(0, 2,   902, 802, 2,  0,  1, 0);
    px(0, 903, 3,   803, 3,  0,  0, 0);
    px(0, 4,   904, 804, 4,  0,  1, 0);
    px(0, 905, 905, 5,   5,  1,  0, 1);
    px(0, 906, 6,   806, 6,  2,  1, 1);
    px(1, 907, 7,   807, 7,  0,  0, 0);
    px(0, 8,   908, 808, 8,  0,  1, 0);
    px(0, 909, 9,   809, 9,  0,  0, 0);
    px(0, 10,  910, 810, 10, 0,  1, 0);
    px(0, 911, 911, 11,  11, 7,  0, 1);
    px(0, 912, 12,  812, 12, 8,  1, 1);
    px(0, 913, 913, 13,  13, 9,  0, 1);
    px(0, 914, 14,  814, 14, 10, 1, 1);

    // SOF without DATA_EN_IN must be ignored: row 2 keeps its D1.
    @(posedge CLK); #1 SOF_IN = 1'b1; DATA_EN_IN = 1'b0;
    px(0, 915, 15, 815, 15, 11, 0, 0);
    idle();

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_bayer_remosaic.md
# rgb_bayer_remosaic

Converts a full-colour RGB pixel stream back into a single-channel Bayer RAW stream and presents it as the two-line tap interface (current-line sample, previous-line sample, column/row parity) consumed by the demosaic stage. Used as a loop-back source for demosaic verification and as the RAW emitter when processed RGB frames must be re-packed for sensor-format storage. Sits between any RGB producer (test-pattern generator, frame reader) and the Bayer demosaic input.

## Interface

- LINE_WIDTH, 640, active pixels per line; line buffer depth; minimum 2.
- DW, 10, bits per colour sample and per RAW sample.
- ROW_W, 12, row counter width.
- CLK  in  1  single clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- SOF_IN  in  1  start of frame; qualified by DATA_EN_IN; marks pixel (0,0).
- DATA_EN_IN  in  1  input pixel valid.
- R_IN, G_IN, B_IN  in  DW each  input colour samples.
- DATA_EN  out  1  output valid.
- D0  out  DW  RAW sample, current line, current column.
- D1  out  DW  RAW sample, previous line, same column (0 on row 0).
- X  out  1  column parity of the D0 sample.
- Y  out  1  row parity of the D0 sample.

## Operation

- Counters col (0..LINE_WIDTH-1) and row (ROW_W bits) advance only on DATA_EN_IN=1.
- Accepted pixel with SOF_IN=1: treated as col=0,row=0; next accepted pixel has col=1,row=0.
- Column wrap: col=LINE_WIDTH-1 accepted -> col=0, row+1. Row wraps modulo 2^ROW_W; parity stays consistent.
- Bayer phase from {row[0],col[0]}: 00 -> G_IN, 01 -> R_IN, 10 -> B_IN, 11 -> G_IN. Selected sample becomes RAW. No arithmetic; pure selection.
- Line delay: circular buffer of LINE_WIDTH entries indexed by col. Per accepted pixel: read entry[col] (previous line's RAW at this column), then write RAW to entry[col].
- D1 forced to 0 while row=0 (buffer contents from earlier frames or power-up are never exposed).
- DATA_EN_IN=0: no counter, buffer or output data change; DATA_EN drops to 0; D0/D1/X/Y hold.
- SOF_IN mid-line or mid-frame: counters restart immediately; partial line discarded; D1 masked to 0 for the new row 0.
- SOF_IN with DATA_EN_IN=0: ignored.

## Timing

- Latency: 1 cycle. Pixel accepted at edge n -> D0, D1, X, Y, DATA_EN=1 valid after edge n+1.
- Throughput: one pixel per cycle, no backpressure; DATA_EN_IN may be asserted every cycle indefinitely.
- Buffer read is synchronous; read and write of the same entry in one cycle return the old (previous-line) value.
- Reset (async assert): DATA_EN=0, D0=0, D1=0, X=0, Y=0, col=0, row=0. Buffer contents not cleared (masked by row=0 rule).
- Reset deassertion mid-stream: first accepted pixel after release is col 0 row 0 whether or not SOF_IN is set.

## Structure

- Shared package bayer_pkg: DW default, phase encodings (PH_GR=2'b00, PH_R=2'b01, PH_B=2'b10, PH_GB=2'b11) and the phase-to-channel mapping, so this block and the demosaic agree on one definition.
- Sub-module raw_line_buffer: single-port-style RAM, depth LINE_WIDTH, width DW, read-before-write, registered output; parameters LINE_WIDTH, DW.
- Top holds counters, phase select, D0/X/Y/DATA_EN registers and the row-0 mask.

## Test plan

- Reset mid-frame, then release: all outputs 0 during reset; first pixel after release yields X=0, Y=0, D1=0.
- LINE_WIDTH=4, two lines, R=100,G=200,B=300 constant: D0 sequence 200,100,200,100 (row 0, D1=0) then 300,200,300,200 with D1=200,100,200,100.
- Bubbles: DATA_EN_IN pattern 1,0,0,1 -> DATA_EN 1,0,0,1 one cycle later; X toggles only across valid outputs; D0 held during gaps.
- Column wrap: LINE_WIDTH=4, 8 consecutive pixels -> X 0,1,0,1,0,1,0,1; Y 0,0,0,0,1,1,1,1.
- SOF_IN on column 2 of row 1 -> that output has X=0, Y=0, D1=0; following row D1 equals RAW from the restarted row.
- Round trip: random 8x4 frame through this block into the demosaic -> demosaic R at phase 01 equals original R_IN at that pixel.
